// File: rtl/cdc_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cdc_arb_pkg
// Description : Shared types and helpers for the CDC bus arbiter.
//               - arb_state_e : transfer sequencer states, 2-bit encoding
//               - cnt_width() : phase-counter width from the hold/gap lengths
// Revision    : 1.0 - initial release
// ============================================================================
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ASSERT = 2'd2,
        GAP    = 2'd3
    } arb_state_e;

    // The counter counts down from N-1 to 0, so it must hold
    // max(hold, gap)-1. One extra bit keeps N=1 from producing a zero width.
    function automatic int cnt_width(input int hold, input int gap);
        int m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m) + 1;
    endfunction

endpackage : cdc_arb_pkg
`default_nettype wire

// File: rtl/cdc_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick. Scans the request vector
//               starting at ptr and wrapping, and returns the first requester.
// Ports       : req     in  NUM_REQ  request levels
//               ptr     in  IDX_W    highest-priority index this round
//               win     out NUM_REQ  one-hot winner (zero if none)
//               win_idx out IDX_W    binary winner index (zero if none)
//               any     out 1        at least one request present
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any
);

    logic [IDX_W-1:0] w_j;

    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        w_j     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!any && req[w_j]) begin
                any      = 1'b1;
                win[w_j] = 1'b1;
                win_idx  = w_j;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/cdc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bus_arbiter
// Description : Source-domain controller sharing one level-enable bus
//               synchroniser channel among NUM_REQ requesters. Round-robin
//               grant, word latched onto unsync_bus, then bus_enable is
//               sequenced SETUP (low) / ASSERT (high) / GAP (low) so the
//               destination sees one rising edge per word with stable data.
// Build macro : CDC_ARB_ACK_EN - adds dst_ack and a 4-phase handshake; the
//               hold/gap timers then become minimums.
// Ports       : clk        in   1                  source clock
//               reset      in   1                  synchronous, active high
//               req        in   NUM_REQ            request levels
//               req_data   in   NUM_REQ*BUS_WIDTH  word i at [i*BUS_WIDTH +: BUS_WIDTH]
//               dst_ack    in   1                  (CDC_ARB_ACK_EN) echoed enable
//               grant      out  NUM_REQ            one-hot 1-cycle capture pulse
//               busy       out  1                  state != IDLE
//               unsync_bus out  BUS_WIDTH          held word to the synchroniser
//               bus_enable out  1                  registered level enable
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_bus_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int BUS_WIDTH   = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
`ifdef CDC_ARB_ACK_EN
    input  logic                           dst_ack,
`endif
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy,
    output logic [BUS_WIDTH-1:0]           unsync_bus,
    output logic                           bus_enable
);

    localparam int c_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    localparam logic [c_CNT_W-1:0] c_HOLD_LOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);

    // Illegal parameter sets stop elaboration instead of building broken logic.
    if (NUM_REQ < 2 || BUS_WIDTH < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || SYNC_STAGES < 1) begin : g_param_check
        $error("cdc_bus_arbiter: illegal parameter value");
    end

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_IDX_W-1:0]     r_ptr;
    logic [NUM_REQ-1:0]     r_grant;
    logic [BUS_WIDTH-1:0]   r_bus;
    logic                   r_bus_enable;

    logic [NUM_REQ-1:0]     w_win;
    logic [c_IDX_W-1:0]     w_win_idx;
    logic                   w_any;
    logic                   w_ack_hi;   // ASSERT may end
    logic                   w_ack_lo;   // GAP may end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .req     (req),
        .ptr     (r_ptr),
        .win     (w_win),
        .win_idx (w_win_idx),
        .any     (w_any)
    );

`ifdef CDC_ARB_ACK_EN
    logic [SYNC_STAGES-1:0] r_ack_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync[0] <= dst_ack;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_ack_sync[i] <= r_ack_sync[i-1];
            end
        end
    end

    assign w_ack_hi = r_ack_sync[SYNC_STAGES-1];
    assign w_ack_lo = ~r_ack_sync[SYNC_STAGES-1];
`else
    assign w_ack_hi = 1'b1;
    assign w_ack_lo = 1'b1;
`endif

    // Next-state and phase counter. The counter saturates at zero so that
    // in the handshake build a phase simply waits for the ack condition.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_nxt = SETUP;
                end
            end
            SETUP: begin
                w_state_nxt = ASSERT;
                w_cnt_nxt   = c_HOLD_LOAD;
            end
            ASSERT: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_ack_hi) begin
                    w_state_nxt = GAP;
                    w_cnt_nxt   = c_GAP_LOAD;
                end
            end
            GAP: begin
                if (r_cnt != '0) begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end else if (w_ack_lo) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_ptr        <= '0;
            r_grant      <= '0;
            r_bus        <= '0;
            r_bus_enable <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            // Registering the decoded next state keeps bus_enable glitch-free
            // toward the other domain.
            r_bus_enable <= (w_state_nxt == ASSERT);
            r_grant      <= '0;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_win;
                r_bus   <= req_data[w_win_idx*BUS_WIDTH +: BUS_WIDTH];
                r_ptr   <= (w_win_idx == c_LAST_IDX) ? '0 : w_win_idx + 1'b1;
            end
        end
    end

    assign grant      = r_grant;
    assign busy       = (r_state != IDLE);
    assign unsync_bus = r_bus;
    assign bus_enable = r_bus_enable;

endmodule : cdc_bus_arbiter
`default_nettype wire

// File: tb/tb_cdc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdc_bus_arbiter
// Description : Self-checking bench for cdc_bus_arbiter (NUM_REQ=4,
//               BUS_WIDTH=8, HOLD=4, GAP=4, SYNC_STAGES=2). Directed vector
//               table for single transfers plus hand-written sequences for
//               reset, round robin, late request and (with CDC_ARB_ACK_EN)
//               the handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdc_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  grant;
    logic        busy;
    logic [7:0]  unsync_bus;
    logic        bus_enable;
`ifdef CDC_ARB_ACK_EN
    logic        dst_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    cdc_bus_arbiter #(
        .NUM_REQ     (4),
        .BUS_WIDTH   (8),
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
`ifdef CDC_ARB_ACK_EN
        .dst_ack    (dst_ack),
`endif
        .grant      (grant),
        .busy       (busy),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable)
    );

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [7:0]  exp_bus;
    } vec_t;

    vec_t vec [7];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance one clock and sample/drive 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (busy && c < budget) begin
            step();
            c++;
        end
        if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [9:0] be_prof;
        logic [9:0] busy_prof;
        logic [7:0] b0;
        int         unstable;
        int         g_idx [5];
        int         g_cyc [5];
        logic [7:0] g_bus [5];
        int         ng;
        int         viol;
        int         cyc;
        logic       prev_be;
        logic [7:0] prev_bus;
        int         early;

        vec[0] = '{4'b0100, 32'hD3A5B1A0, 4'b0100, 8'hA5};
        vec[1] = '{4'b1001, 32'h3C5A6978, 4'b1000, 8'h3C};
        vec[2] = '{4'b1001, 32'h11223344, 4'b0001, 8'h44};
        vec[3] = '{4'b0001, 32'hFF00EE0F, 4'b0001, 8'h0F};
        vec[4] = '{4'b0110, 32'h12345678, 4'b0010, 8'h56};
        vec[5] = '{4'b0011, 32'h9ABCDEF0, 4'b0001, 8'hF0};
        vec[6] = '{4'b1000, 32'h80402010, 4'b1000, 8'h80};

        // ---------------- reset state ----------------
        reset = 1'b1;
        step();
        step();
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_bus", {24'd0, unsync_bus}, 32'd0);
        chk("rst_be", {31'd0, bus_enable}, 32'd0);
        reset = 1'b0;
        step();

`ifdef CDC_ARB_ACK_EN
        // ---------------- handshake ----------------
        dst_ack = 1'b0;
        req = 4'b0001;
        req_data = 32'h000000C7;
        step();
        chk("ack_grant", {28'd0, grant}, 32'h1);
        req = '0;
        step();
        chk("ack_be_rise", {31'd0, bus_enable}, 32'd1);
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus_enable) cyc++;
        end
        chk("ack_be_held", cyc, 32'd20);
        dst_ack = 1'b1;
        step();
        step();
        chk("ack_be_before_fall", {31'd0, bus_enable}, 32'd1);
        step();
        chk("ack_be_fall", {31'd0, bus_enable}, 32'd0);
        for (int i = 0; i < 8; i++) step();
        chk("ack_gap_wait", {31'd0, busy}, 32'd1);
        dst_ack = 1'b0;
        step();
        step();
        chk("ack_busy_before_idle", {31'd0, busy}, 32'd1);
        step();
        chk("ack_idle", {31'd0, busy}, 32'd0);
        chk("ack_bus_held", {24'd0, unsync_bus}, 32'hC7);
`else
        // ---------------- table-driven single transfers ----------------
        for (int v = 0; v < 7; v++) begin
            wait_idle(40);
            req      = vec[v].req;
            req_data = vec[v].data;
            step();
            chk($sformatf("v%0d_grant", v), {28'd0, grant}, {28'd0, vec[v].exp_grant});
            chk($sformatf("v%0d_bus", v), {24'd0, unsync_bus}, {24'd0, vec[v].exp_bus});
            req = '0;
            b0 = unsync_bus;
            unstable = 0;
            be_prof = '0;
            busy_prof = '0;
            be_prof[0] = bus_enable;
            busy_prof[0] = busy;
            for (int s = 1; s < 10; s++) begin
                step();
                be_prof[s] = bus_enable;
                busy_prof[s] = busy;
                if (unsync_bus !== b0) unstable++;
                if (grant !== 4'b0000) unstable++;
            end
            chk($sformatf("v%0d_be_profile", v), {22'd0, be_prof}, {22'd0, 10'b00_0001_1110});
            chk($sformatf("v%0d_busy_profile", v), {22'd0, busy_prof}, {22'd0, 10'b01_1111_1111});
            chk($sformatf("v%0d_bus_stable", v), unstable, 32'd0);
        end

        // ---------------- reset mid-ASSERT ----------------
        wait_idle(40);
        req = 4'b0100;
        req_data = 32'hD3A5B1A0;
        step();
        req = '0;
        step();
        step();
        chk("mid_be_high", {31'd0, bus_enable}, 32'd1);
        reset = 1'b1;
        step();
        chk("mid_rst_be", {31'd0, bus_enable}, 32'd0);
        chk("mid_rst_bus", {24'd0, unsync_bus}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        req = 4'b1111;
        step();
        chk("post_rst_grant", {28'd0, grant}, 32'h1);
        chk("post_rst_bus", {24'd0, unsync_bus}, 32'hA0);
        req = '0;
        wait_idle(40);

        // ---------------- round robin, all requesting ----------------
        reset = 1'b1;
        step();
        reset = 1'b0;
        req_data = 32'h44332211;
        req = 4'b1111;
        ng = 0;
        viol = 0;
        prev_be = 1'b0;
        prev_bus = '0;
        for (int c = 0; c < 70 && ng < 5; c++) begin
            step();
            if (grant != 4'b0000) begin
                g_idx[ng] = (grant == 4'b0001) ? 0 : (grant == 4'b0010) ? 1 :
                            (grant == 4'b0100) ? 2 : (grant == 4'b1000) ? 3 : 9;
                g_cyc[ng] = c;
                g_bus[ng] = unsync_bus;
                ng++;
            end
            if (bus_enable && prev_be && unsync_bus !== prev_bus) viol++;
            prev_be = bus_enable;
            prev_bus = unsync_bus;
        end
        req = '0;
        chk("rr_count", ng, 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < ng) begin
                chk($sformatf("rr_order%0d", i), g_idx[i], i % 4);
                chk($sformatf("rr_bus%0d", i), {24'd0, g_bus[i]}, 32'h11 * ((i % 4) + 1));
                if (i > 0) chk($sformatf("rr_spacing%0d", i), g_cyc[i] - g_cyc[i-1], 32'd10);
            end
        end
        // Keep watching the last transfer for data movement under enable.
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus_enable && prev_be && unsync_bus !== prev_bus) viol++;
            prev_be = bus_enable;
            prev_bus = unsync_bus;
        end
        chk("rr_bus_stable", viol, 32'd0);
        wait_idle(40);

        // ---------------- late request during GAP ----------------
        // Pointer is 1 here, so req0 is found after wrapping.
        req_data = 32'h5D6C7B8A;
        req = 4'b0001;
        step();
        chk("late_first_grant", {28'd0, grant}, 32'h1);
        req = '0;
        early = 0;
        for (int s = 1; s < 10; s++) begin
            step();
            if (s == 6) req = 4'b0010;
            if (grant != 4'b0000) early++;
        end
        chk("late_no_early_grant", early, 32'd0);
        chk("late_idle_reached", {31'd0, busy}, 32'd0);
        step();
        chk("late_grant", {28'd0, grant}, 32'h2);
        chk("late_bus", {24'd0, unsync_bus}, 32'h7B);
        req = '0;
        wait_idle(40);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_cdc_bus_arbiter
`default_nettype wire
